// File: rtl/ds_arb_rr.sv
// Round-robin arbiter sharing one valid/ready write stream between N requesters.
// The grant is held across stalled beats and, with LOCK=1, across whole packets.
module ds_arb_rr #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int LOCK = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N-1:0]         i_vld,
    output logic [N-1:0]         o_rdy,
    input  logic [N*DW-1:0]      i_data,
    input  logic [N-1:0]         i_last,
    output logic                 o_vld,
    input  logic                 i_rdy,
    output logic [DW-1:0]        o_data,
    output logic                 o_last,
    output logic [$clog2(N)-1:0] o_grant,
    output logic                 o_gnt_vld
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LCKD = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   gnt_q, gnt_nxt;
    logic [IW-1:0]   sel, g;
    logic            found, active, xfer, close;

    // Modulo-N increment; N need not be a power of two.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] k);
        if (k == IW'(N - 1)) return '0;
        return k + IW'(1);
    endfunction

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = ptr;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && i_vld[IW'(idx)]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

    always_comb begin
        g         = (state == IDLE) ? sel : gnt_q;
        active    = !i_rst && ((state != IDLE) || found);
        o_vld     = active && i_vld[g];
        o_data    = i_data[int'(g)*DW +: DW];
        o_last    = i_last[g];
        o_rdy     = '0;
        if (active && i_rdy) o_rdy[g] = 1'b1;
        o_grant   = i_rst ? '0 : g;
        o_gnt_vld = active;
        xfer      = o_vld && i_rdy;
        close     = (LOCK == 0) || i_last[g];
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt_q;
        case (state)
            IDLE, HOLD: begin
                if (xfer) begin
                    if (close) begin
                        state_nxt = IDLE;
                        ptr_nxt   = wrap_inc(g);
                    end else begin
                        state_nxt = LCKD;
                        gnt_nxt   = g;
                    end
                end else if (state == IDLE && found) begin
                    // Offered beat stalled: pin the grant until it moves.
                    state_nxt = HOLD;
                    gnt_nxt   = g;
                end
            end
            LCKD: begin
                if (xfer && i_last[g]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = wrap_inc(g);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            ptr   <= '0;
            gnt_q <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt_q <= gnt_nxt;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert ($onehot0(o_rdy));
            assert ({1'b0, gnt_q} < (IW + 1)'(N));
        end
    end

    a_grant_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_vld && !i_rdy) |=> $stable(o_grant));
`endif

endmodule

// File: tb/tb_ds_arb_rr.sv
// Bench for ds_arb_rr: three instances (N=4 locked, N=4 per-beat, N=3 locked)
// driven from vector records, with expected outputs queued and compared per cycle.
module tb_ds_arb_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [3:0]  a_vld, a_last, a_ordy;
    logic        a_irdy, a_ovld, a_olast, a_gv;
    logic [31:0] a_data;
    logic [7:0]  a_odata;
    logic [1:0]  a_grant;

    logic [3:0]  b_vld, b_last, b_ordy;
    logic        b_irdy, b_ovld, b_olast, b_gv;
    logic [31:0] b_data;
    logic [7:0]  b_odata;
    logic [1:0]  b_grant;

    logic [2:0]  c_vld, c_last, c_ordy;
    logic        c_irdy, c_ovld, c_olast, c_gv;
    logic [23:0] c_data;
    logic [7:0]  c_odata;
    logic [1:0]  c_grant;

    ds_arb_rr #(.N(4), .DW(8), .LOCK(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_vld(a_vld), .o_rdy(a_ordy), .i_data(a_data),
        .i_last(a_last), .o_vld(a_ovld), .i_rdy(a_irdy), .o_data(a_odata),
        .o_last(a_olast), .o_grant(a_grant), .o_gnt_vld(a_gv));

    ds_arb_rr #(.N(4), .DW(8), .LOCK(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_vld(b_vld), .o_rdy(b_ordy), .i_data(b_data),
        .i_last(b_last), .o_vld(b_ovld), .i_rdy(b_irdy), .o_data(b_odata),
        .o_last(b_olast), .o_grant(b_grant), .o_gnt_vld(b_gv));

    ds_arb_rr #(.N(3), .DW(8), .LOCK(1)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_vld(c_vld), .o_rdy(c_ordy), .i_data(c_data),
        .i_last(c_last), .o_vld(c_ovld), .i_rdy(c_irdy), .o_data(c_odata),
        .o_last(c_olast), .o_grant(c_grant), .o_gnt_vld(c_gv));

    typedef struct {
        int         unit;
        logic [3:0] vld;
        logic [3:0] last;
        logic       rdy;
        logic       ev;
        logic [1:0] eg;
        logic [3:0] erdy;
        logic       el;
        logic       egv;
    } vec_t;

    typedef struct {
        int         unit;
        logic       ev;
        logic [1:0] eg;
        logic [3:0] erdy;
        logic       el;
        logic       egv;
        logic [7:0] ed;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[10];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int u, input logic [3:0] vld, input logic [3:0] last,
                                input logic rdy, input logic ev, input logic [1:0] eg,
                                input logic [3:0] erdy, input logic el, input logic egv);
        vec_t v;
        v.unit = u; v.vld = vld; v.last = last; v.rdy = rdy;
        v.ev = ev; v.eg = eg; v.erdy = erdy; v.el = el; v.egv = egv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cmp(input string pfx, input exp_t e, input logic ov, input logic [1:0] og,
                       input logic [3:0] ordy, input logic ol, input logic gv,
                       input logic [7:0] od);
        chk({pfx, ".o_vld"}, 32'(ov), 32'(e.ev));
        chk({pfx, ".o_grant"}, 32'(og), 32'(e.eg));
        chk({pfx, ".o_rdy"}, 32'(ordy), 32'(e.erdy));
        chk({pfx, ".o_gnt_vld"}, 32'(gv), 32'(e.egv));
        if (e.ev) begin
            chk({pfx, ".o_last"}, 32'(ol), 32'(e.el));
            chk({pfx, ".o_data"}, 32'(od), 32'(e.ed));
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        case (v.unit)
            0: begin a_vld = v.vld; a_last = v.last; a_irdy = v.rdy; end
            1: begin b_vld = v.vld; b_last = v.last; b_irdy = v.rdy; end
            default: begin c_vld = v.vld[2:0]; c_last = v.last[2:0]; c_irdy = v.rdy; end
        endcase
        e.unit = v.unit; e.ev = v.ev; e.eg = v.eg; e.erdy = v.erdy;
        e.el = v.el; e.egv = v.egv; e.ed = 8'h28 + {6'd0, v.eg};
        sbq.push_back(e);
        @(negedge clk);
        got = sbq.pop_front();
        case (got.unit)
            0: cmp("a", got, a_ovld, a_grant, a_ordy, a_olast, a_gv, a_odata);
            1: cmp("b", got, b_ovld, b_grant, b_ordy, b_olast, b_gv, b_odata);
            default: cmp("c", got, c_ovld, c_grant, {1'b0, c_ordy}, c_olast, c_gv, c_odata);
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Two-beat packets from all four requesters: 0,0,1,1,2,2,3,3,0,0.
        for (int i = 0; i < 10; i++) begin
            tbl[i] = mk(0, 4'b1111, (i % 2 == 1) ? 4'b1111 : 4'b0000, 1'b1,
                        1'b1, 2'((i / 2) % 4), 4'(1 << ((i / 2) % 4)), 1'(i % 2), 1'b1);
        end

        rst    = 1'b1;
        a_data = {8'h2B, 8'h2A, 8'h29, 8'h28};
        b_data = {8'h2B, 8'h2A, 8'h29, 8'h28};
        c_data = {8'h2A, 8'h29, 8'h28};
        a_vld = 4'hF; b_vld = 4'hF; c_vld = 3'h7;
        a_last = '0; b_last = '0; c_last = '0;
        a_irdy = 1'b1; b_irdy = 1'b1; c_irdy = 1'b1;
        @(posedge clk);
        #1;

        // Reset holds every output quiet even with all requests and ready high.
        step(mk(0, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
        step(mk(1, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
        step(mk(2, 4'b0111, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
        rst   = 1'b0;
        b_vld = '0;
        c_vld = '0;

        for (int i = 0; i < 10; i++) step(tbl[i]);

        // Per-beat arbitration between requesters 1 and 3.
        step(mk(1, 4'b1010, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1));
        step(mk(1, 4'b1010, 4'b0010, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b1));
        step(mk(1, 4'b1010, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1));
        step(mk(1, 4'b1010, 4'b0010, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b1));
        b_vld = '0;

        // Stall on requester 2; requester 1 arrives with higher priority but must wait.
        step(mk(0, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b1));
        step(mk(0, 4'b0110, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b1));
        step(mk(0, 4'b0110, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b1));
        step(mk(0, 4'b0101, 4'b0101, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1));
        step(mk(0, 4'b0001, 4'b0101, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));

        // Locked packet on requester 1 with a gap; requester 3 stays blocked.
        step(mk(0, 4'b1010, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b1));
        step(mk(0, 4'b1000, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b0, 1'b1));
        step(mk(0, 4'b1000, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b0, 1'b1));
        step(mk(0, 4'b1010, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1));
        step(mk(0, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1));
        a_vld = '0;

        // N=3 wrap: move ptr to 2, then all valid gives 2,0,1,2.
        step(mk(2, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1));
        step(mk(2, 4'b0111, 4'b0111, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1));
        step(mk(2, 4'b0111, 4'b0111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
        step(mk(2, 4'b0111, 4'b0111, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1));
        step(mk(2, 4'b0111, 4'b0111, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1));
        c_vld = '0;

        // Reset while locked on requester 2; afterwards arbitration restarts at 0.
        step(mk(0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b1));
        rst = 1'b1;
        step(mk(0, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
        rst = 1'b0;
        step(mk(0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1));
        step(mk(0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
